// File: rtl/bitty_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | bitty_fetch_unit: issues a locally stored program to BittyCore one           |
// | instruction at a time. Optional watchdog: BITTY_FETCH_TIMEOUT_EN. Rev 1.0    |
// +------------------------------------------------------------------------------+
module bitty_fetch_unit #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  output logic [DATA_W-1:0] instruction,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] last_result,
  output logic [ADDR_W:0]   retired,
  output logic              timeout_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LW    = ADDR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_RETIRE = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   len;
  logic              exec_first;
  logic [DATA_W-1:0] done_result;
  logic              idle_like;
  logic              load_ok;
  logic              start_ok;
  logic              done_ok;
  logic              timeout_hit;
  logic [ADDR_W:0]   retired_inc;

  assign idle_like   = (state == S_IDLE) || (state == S_HALT);
  assign load_ok     = idle_like && load_en;
  assign start_ok    = idle_like && start && !load_en;
  // The first EXEC cycle never accepts done, so a done level left over from
  // the previous instruction cannot retire the new one.
  assign done_ok     = (state == S_EXEC) && !exec_first && core_done;
  assign retired_inc = retired + LW'(1);
  assign busy        = (state == S_FETCH) || (state == S_EXEC) || (state == S_RETIRE);
  assign halted      = (state == S_HALT);

  // Program memory survives reset.
  always_ff @(posedge clk) begin
    if (reset && load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      retired     <= '0;
      last_result <= '0;
      instruction <= '0;
      len         <= '0;
      exec_first  <= 1'b0;
      done_result <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start_ok) begin
            len     <= prog_len;
            pc      <= '0;
            retired <= '0;
            state   <= (prog_len == '0) ? S_HALT : S_FETCH;
          end
        end
        S_FETCH: begin
          instruction <= mem[pc];
          exec_first  <= 1'b1;
          state       <= S_EXEC;
        end
        S_EXEC: begin
          exec_first <= 1'b0;
          if (done_ok) begin
            done_result <= core_result;
            instruction <= '0;
            state       <= S_RETIRE;
          end else if (timeout_hit) begin
            instruction <= '0;
            state       <= S_HALT;
          end
        end
        S_RETIRE: begin
          last_result <= done_result;
          retired     <= retired_inc;
          pc          <= pc + ADDR_W'(1);
          state       <= (retired_inc == len) ? S_HALT : S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BITTY_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] exec_cnt;
  logic          timeout_flag;

  assign timeout_hit = (state == S_EXEC) && !done_ok && (exec_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_flag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      exec_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (start_ok) begin
        timeout_flag <= 1'b0;
      end else if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
      if (state == S_FETCH) begin
        exec_cnt <= '0;
      end else if (state == S_EXEC) begin
        exec_cnt <= exec_cnt + TW'(1);
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule
`default_nettype wire
